// File: rtl/dec_key_pkg.sv
// Shared types and helpers for the decimal key to BCD sequencing controller.
package dec_key_pkg;

  localparam int NUM_KEYS = 10;
  localparam int BCD_W    = 4;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    EMIT,
    WAIT_REL
  } state_e;

  function automatic logic [3:0] popcount10(input logic [NUM_KEYS-1:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < NUM_KEYS; i++) n = n + {3'b000, v[i]};
    return n;
  endfunction

  function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
    return popcount10(v) == 4'd1;
  endfunction

  function automatic logic [BCD_W-1:0] onehot10_to_bcd(input logic [NUM_KEYS-1:0] v);
    logic [BCD_W-1:0] d;
    d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (v[i]) d = BCD_W'(i);
    end
    return d;
  endfunction

endpackage

// File: rtl/dec_key_bcd_ctrl_fifo.sv
// Synchronous show-ahead FIFO holding accepted BCD digits.
module bcd_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is still taken when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign count   = count_q;
  assign dout    = empty ? '0 : mem_q[rd_q];

  // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop)  rd_q <= rd_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage is not reset; dout is masked while empty so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/dec_key_bcd_ctrl.sv
// Debounces ten decimal key lines, rejects multi-key presses and queues one BCD digit per press.
module dec_key_bcd_ctrl
  import dec_key_pkg::*;
#(
  parameter int DEB_CYCLES = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_KEYS-1:0]           key_in,
  output logic [BCD_W-1:0]              bcd_out,
  output logic                          bcd_valid,
  input  logic                          bcd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          multi_err,
  output logic                          ovf,
  input  logic                          ovf_clr
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  logic [NUM_KEYS-1:0] sync1_q, sync_q;
  state_e              state_q, state_d;
  logic [NUM_KEYS-1:0] snap_q, snap_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                push, pop, full, empty;
  logic                multi_err_q, multi_err_d;
  logic                ovf_q, ovf_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q     <= '0;
      sync_q      <= '0;
      state_q     <= IDLE;
      snap_q      <= '0;
      cnt_q       <= '0;
      multi_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      sync1_q     <= key_in;
      sync_q      <= sync1_q;
      state_q     <= state_d;
      snap_q      <= snap_d;
      cnt_q       <= cnt_d;
      multi_err_q <= multi_err_d;
      ovf_q       <= ovf_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    cnt_d       = cnt_q;
    push        = 1'b0;
    multi_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sync_q != '0) begin
          snap_d  = sync_q;
          cnt_d   = '0;
          state_d = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (sync_q == '0) begin
          state_d = IDLE;
        end else if (sync_q != snap_q) begin
          snap_d = sync_q;
          cnt_d  = '0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end else if (is_onehot(snap_q)) begin
          state_d = EMIT;
        end else begin
          multi_err_d = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT_REL;
        end
      end
      EMIT: begin
        push    = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_REL;
      end
      WAIT_REL: begin
        if (sync_q != '0)        cnt_d   = '0;
        else if (cnt_q == CNT_MAX) state_d = IDLE;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  assign pop   = !empty && bcd_ready;
  // Set has priority over the clear request.
  assign ovf_d = (push && full && !pop) || (ovf_q && !ovf_clr);

  bcd_fifo #(
    .WIDTH(BCD_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  (onehot10_to_bcd(snap_q)),
    .pop  (pop),
    .dout (bcd_out),
    .count(fifo_count),
    .full (full),
    .empty(empty)
  );

  assign bcd_valid = !empty;
  assign multi_err = multi_err_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_dec_key_bcd_ctrl.sv
// Directed self-checking bench for dec_key_bcd_ctrl at default parameters.
module tb_dec_key_bcd_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] key_in;
  logic [3:0] bcd_out;
  logic       bcd_valid;
  logic       bcd_ready;
  logic [2:0] fifo_count;
  logic       multi_err;
  logic       ovf;
  logic       ovf_clr;

  int n_total = 0;
  int n_bad   = 0;

  dec_key_bcd_ctrl #(.DEB_CYCLES(4), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_in    (key_in),
    .bcd_out   (bcd_out),
    .bcd_valid (bcd_valid),
    .bcd_ready (bcd_ready),
    .fifo_count(fifo_count),
    .multi_err (multi_err),
    .ovf       (ovf),
    .ovf_clr   (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press(input logic [9:0] k, input int hold);
    key_in = k;
    tick(hold);
    key_in = '0;
    tick(8);
  endtask

  // digits packed one nibble per entry, head in bits [3:0]
  task automatic drain_check(input logic [15:0] digits, input int n);
    bcd_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      check("drain_valid", int'(bcd_valid), 1);
      check("drain_digit", int'(bcd_out), int'(digits[4*i +: 4]));
      tick(1);
    end
    bcd_ready = 1'b0;
    check("drain_empty_valid", int'(bcd_valid), 0);
    check("drain_empty_count", int'(fifo_count), 0);
    check("drain_empty_out", int'(bcd_out), 0);
  endtask

  initial begin
    int pulses;
    logic [15:0] exp_digits;
    logic [3:0]  d;

    rst_n     = 1'b0;
    key_in    = '0;
    bcd_ready = 1'b0;
    ovf_clr   = 1'b0;
    tick(2);
    check("rst_valid", int'(bcd_valid), 0);
    check("rst_out", int'(bcd_out), 0);
    check("rst_count", int'(fifo_count), 0);
    check("rst_multi", int'(multi_err), 0);
    check("rst_ovf", int'(ovf), 0);
    rst_n = 1'b1;
    tick(2);

    // single press, latency edge t+7
    key_in = 10'h080;
    tick(7);
    check("d7_valid_early", int'(bcd_valid), 0);
    tick(1);
    check("d7_valid", int'(bcd_valid), 1);
    check("d7_digit", int'(bcd_out), 7);
    check("d7_count", int'(fifo_count), 1);
    tick(12);
    key_in = '0;
    tick(10);
    check("d7_no_repeat", int'(fifo_count), 1);
    drain_check(16'h0007, 1);

    // bounce then steady hold
    key_in = 10'h008; tick(1);
    key_in = '0;      tick(1);
    key_in = 10'h008; tick(1);
    key_in = '0;      tick(1);
    key_in = 10'h008; tick(10);
    key_in = '0;      tick(10);
    check("bounce_count", int'(fifo_count), 1);
    check("bounce_digit", int'(bcd_out), 3);
    drain_check(16'h0003, 1);

    // short glitch is rejected
    key_in = 10'h008; tick(2);
    key_in = '0;      tick(10);
    check("glitch_count", int'(fifo_count), 0);

    // multi-key press
    pulses = 0;
    key_in = 10'h028;
    for (int i = 0; i < 20; i++) begin
      if (i == 10) key_in = '0;
      tick(1);
      if (multi_err) pulses++;
    end
    check("multi_pulses", pulses, 1);
    check("multi_count", int'(fifo_count), 0);
    press(10'h020, 8);
    check("multi_then_d5_count", int'(fifo_count), 1);
    check("multi_then_d5_digit", int'(bcd_out), 5);
    drain_check(16'h0005, 1);

    // overflow with consumer stalled
    press(10'h002, 8);
    press(10'h004, 8);
    press(10'h001, 8);
    press(10'h200, 8);
    check("ovf_pre", int'(ovf), 0);
    press(10'h010, 8);
    check("ovf_count", int'(fifo_count), 4);
    check("ovf_set", int'(ovf), 1);
    check("ovf_head", int'(bcd_out), 1);
    drain_check(16'h9021, 4);
    check("ovf_sticky", int'(ovf), 1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", int'(ovf), 0);

    // push and pop on the same edge while full
    press(10'h002, 8);
    press(10'h004, 8);
    press(10'h008, 8);
    press(10'h010, 8);
    check("full_count", int'(fifo_count), 4);
    key_in = 10'h040;
    tick(7);
    bcd_ready = 1'b1;
    tick(1);
    bcd_ready = 1'b0;
    key_in = '0;
    tick(8);
    check("pp_count", int'(fifo_count), 4);
    check("pp_ovf", int'(ovf), 0);
    check("pp_head", int'(bcd_out), 2);
    drain_check(16'h6432, 4);

    // fill/drain rounds to wrap the pointers
    for (int r = 0; r < 3; r++) begin
      exp_digits = '0;
      for (int i = 0; i < 4; i++) begin
        d = 4'((3 * r + i + 1) % 10);
        exp_digits[4*i +: 4] = d;
        press(10'(1) << d, 8);
      end
      check("wrap_count", int'(fifo_count), 4);
      drain_check(exp_digits, 4);
    end
    check("wrap_ovf", int'(ovf), 0);

    // reset during debounce with a key still held
    press(10'h004, 8);
    check("prerst_count", int'(fifo_count), 1);
    key_in = 10'h100;
    tick(4);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", int'(bcd_valid), 0);
    check("midrst_out", int'(bcd_out), 0);
    check("midrst_count", int'(fifo_count), 0);
    check("midrst_multi", int'(multi_err), 0);
    tick(2);
    rst_n = 1'b1;
    tick(7);
    check("postrst_valid_early", int'(bcd_valid), 0);
    tick(1);
    check("postrst_valid", int'(bcd_valid), 1);
    check("postrst_digit", int'(bcd_out), 8);
    key_in = '0;
    tick(8);
    drain_check(16'h0008, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
